// File: rtl/fp_term_sequencer_pkg.sv
// Shared types and constants for the FP32 term sequencer (ka*a^2 + kb*b^2 == kc*c^2).
package fp_term_sequencer_pkg;

    localparam int SEQ_IN_W = 5;
    localparam int SEQ_FP_W = 32;

    localparam logic [31:0] FP_ONE  = 32'h3F80_0000;
    localparam logic [31:0] FP_ZERO = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MUL_A = 3'd1,
        ST_MUL_B = 3'd2,
        ST_MUL_C = 3'd3,
        ST_ADD   = 3'd4,
        ST_CMP   = 3'd5,
        ST_DONE  = 3'd6
    } state_e;

    function automatic logic is_mul_phase(input state_e s);
        return (s == ST_MUL_A) || (s == ST_MUL_B) || (s == ST_MUL_C);
    endfunction

endpackage

// File: rtl/fp_term_sequencer_watchdog.sv
// Per-phase cycle counter that flags a phase which waited TIMEOUT cycles without an ack.
// Only built when FP_SEQ_WDOG_EN is defined.
`ifdef FP_SEQ_WDOG_EN
module fp_seq_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic active_i,
    input  logic clear_i,
    output logic expire_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear_i || !active_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expire_o = active_i && (cnt_q == CNT_W'(TIMEOUT - 1));

endmodule
`endif

// File: rtl/fp_term_sequencer.sv
// Time-multiplexes one FP32 multiplier and one adder to evaluate ka*a*a + kb*b*b == kc*c*c.
// Optional per-phase watchdog abort is enabled by defining FP_SEQ_WDOG_EN.
module fp_term_sequencer
    import fp_term_sequencer_pkg::*;
#(
    parameter int IN_W = SEQ_IN_W,
    parameter int FP_W = SEQ_FP_W
`ifdef FP_SEQ_WDOG_EN
   ,parameter int TIMEOUT = 255
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [IN_W-1:0] a,
    input  logic [IN_W-1:0] b,
    input  logic [IN_W-1:0] c,
    input  logic [FP_W-1:0] coef_a,
    input  logic [FP_W-1:0] coef_b,
    input  logic [FP_W-1:0] coef_c,
    output logic            busy,
    output logic            mul_req,
    output logic [IN_W-1:0] mul_x,
    output logic [FP_W-1:0] mul_k,
    input  logic            mul_ack,
    input  logic [FP_W-1:0] mul_res,
    output logic            add_req,
    output logic [FP_W-1:0] add_x,
    output logic [FP_W-1:0] add_y,
    input  logic            add_ack,
    input  logic [FP_W-1:0] add_res,
    output logic            done,
    output logic            sig,
    output logic            err
);

    state_e          state_q;
    logic [IN_W-1:0] a_q, b_q, c_q;
    logic [FP_W-1:0] ka_q, kb_q, kc_q;
    logic [FP_W-1:0] prod_a_q, prod_b_q, prod_c_q, sum_q;
    logic            busy_q, mul_req_q, add_req_q, done_q, sig_q, err_q;
    logic            phase_ack;
    logic            wdog_expire;

    // An ack only counts in the phase it belongs to; stray acks fall through.
    assign phase_ack = (is_mul_phase(state_q) && mul_ack) || ((state_q == ST_ADD) && add_ack);

`ifdef FP_SEQ_WDOG_EN
    fp_seq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .active_i (is_mul_phase(state_q) || (state_q == ST_ADD)),
        .clear_i  (phase_ack),
        .expire_o (wdog_expire)
    );
`else
    assign wdog_expire = 1'b0;
`endif

    // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
    always_comb begin
        mul_x = '0;
        mul_k = '0;
        case (state_q)
            ST_MUL_A: begin mul_x = a_q; mul_k = ka_q; end
            ST_MUL_B: begin mul_x = b_q; mul_k = kb_q; end
            ST_MUL_C: begin mul_x = c_q; mul_k = kc_q; end
            default:  ;
        endcase
    end

    // NOTE: the operand latches and products are small flops, so they are reset like the control state.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            ka_q      <= '0;
            kb_q      <= '0;
            kc_q      <= '0;
            prod_a_q  <= '0;
            prod_b_q  <= '0;
            prod_c_q  <= '0;
            sum_q     <= '0;
            busy_q    <= 1'b0;
            mul_req_q <= 1'b0;
            add_req_q <= 1'b0;
            done_q    <= 1'b0;
            sig_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (wdog_expire && !phase_ack) begin
                mul_req_q <= 1'b0;
                add_req_q <= 1'b0;
                err_q     <= 1'b1;
                sig_q     <= 1'b0;
                done_q    <= 1'b1;
                state_q   <= ST_DONE;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            a_q       <= a;
                            b_q       <= b;
                            c_q       <= c;
                            ka_q      <= coef_a;
                            kb_q      <= coef_b;
                            kc_q      <= coef_c;
                            sig_q     <= 1'b0;
                            err_q     <= 1'b0;
                            busy_q    <= 1'b1;
                            mul_req_q <= 1'b1;
                            state_q   <= ST_MUL_A;
                        end
                    end
                    ST_MUL_A: if (mul_ack) begin prod_a_q <= mul_res; state_q <= ST_MUL_B; end
                    ST_MUL_B: if (mul_ack) begin prod_b_q <= mul_res; state_q <= ST_MUL_C; end
                    ST_MUL_C: begin
                        if (mul_ack) begin
                            prod_c_q  <= mul_res;
                            mul_req_q <= 1'b0;
                            add_req_q <= 1'b1;
                            state_q   <= ST_ADD;
                        end
                    end
                    ST_ADD: begin
                        if (add_ack) begin
                            sum_q     <= add_res;
                            add_req_q <= 1'b0;
                            state_q   <= ST_CMP;
                        end
                    end
                    ST_CMP: begin
                        // Bitwise on purpose: +0/-0 and NaN payloads are distinct results.
                        sig_q   <= (sum_q == prod_c_q);
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                    ST_DONE: begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign busy    = busy_q;
    assign mul_req = mul_req_q;
    assign add_req = add_req_q;
    assign add_x   = prod_a_q;
    assign add_y   = prod_b_q;
    assign done    = done_q;
    assign sig     = sig_q;
    assign err     = err_q;

endmodule

// File: tb/tb_fp_term_sequencer.sv
// Self-checking bench: behavioural FP32 mul/add units with programmable ack delay, directed and random runs.
module tb_fp_term_sequencer;
    import fp_term_sequencer_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [4:0]  a = '0, b = '0, c = '0;
    logic [31:0] coef_a = '0, coef_b = '0, coef_c = '0;
    logic        busy, mul_req, add_req, done, sig, err;
    logic [4:0]  mul_x;
    logic [31:0] mul_k, add_x, add_y;
    logic        mul_ack = 1'b0, add_ack = 1'b0;
    logic [31:0] mul_res = '0, add_res = '0;

    int n_checks = 0;
    int n_errors = 0;
    int mul_dly = 0, add_dly = 0;
    bit mul_never = 1'b0;

    always #5 clk = ~clk;

`ifdef FP_SEQ_WDOG_EN
    fp_term_sequencer #(.TIMEOUT(16)) dut (
`else
    fp_term_sequencer dut (
`endif
        .clk(clk), .rst_n(rst_n), .start(start),
        .a(a), .b(b), .c(c),
        .coef_a(coef_a), .coef_b(coef_b), .coef_c(coef_c),
        .busy(busy),
        .mul_req(mul_req), .mul_x(mul_x), .mul_k(mul_k), .mul_ack(mul_ack), .mul_res(mul_res),
        .add_req(add_req), .add_x(add_x), .add_y(add_y), .add_ack(add_ack), .add_res(add_res),
        .done(done), .sig(sig), .err(err)
    );

    // FP32 <-> real for zeros and normals, exact for the small values used here.
    function automatic logic [31:0] to_f32(input real r);
        logic [63:0] d;
        d = $realtobits(r);
        if (d[62:52] == 11'd0) return {d[63], 31'd0};
        return {d[63], 8'(int'(d[62:52]) - 1023 + 127), d[51:29]};
    endfunction

    function automatic real to_real(input logic [31:0] f);
        if (f[30:23] == 8'd0) return $bitstoreal({f[31], 63'd0});
        return $bitstoreal({f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] fmul(input logic [4:0] x, input logic [31:0] k);
        int xi;
        xi = int'(x);
        return to_f32(real'(xi * xi) * to_real(k));
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
        return to_f32(to_real(x) + to_real(y));
    endfunction

    // Shared-unit models: ack after the programmed number of wait cycles, result valid with ack.
    int mcnt = 0, acnt = 0;
    always @(posedge clk) begin
        #1;
        if (!rst_n || !mul_req || mul_never) begin
            mul_ack = 1'b0;
            mcnt = 0;
        end else if (mcnt == mul_dly) begin
            mul_ack = 1'b1;
            mul_res = fmul(mul_x, mul_k);
            mcnt = 0;
        end else begin
            mul_ack = 1'b0;
            mcnt++;
        end
    end

    always @(posedge clk) begin
        #1;
        if (!rst_n || !add_req) begin
            add_ack = 1'b0;
            acnt = 0;
        end else if (acnt == add_dly) begin
            add_ack = 1'b1;
            add_res = fadd(add_x, add_y);
            acnt = 0;
        end else begin
            add_ack = 1'b0;
            acnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full operation; poke re-pulses start mid-run (with new operands) and in the DONE cycle.
    task automatic run_op(input string tag,
                          input logic [4:0] ta, input logic [4:0] tb, input logic [4:0] tc,
                          input logic [31:0] tka, input logic [31:0] tkb, input logic [31:0] tkc,
                          input int dm, input int da, input bit poke);
        logic [31:0] pa, pb, pc;
        logic [4:0]  xq[$];
        logic [31:0] kq[$];
        logic [31:0] ax, ay;
        int cyc, ndone, lat;
        bit seen;
        pa = fmul(ta, tka);
        pb = fmul(tb, tkb);
        pc = fmul(tc, tkc);
        mul_dly = dm;
        add_dly = da;
        a = ta; b = tb; c = tc;
        coef_a = tka; coef_b = tkb; coef_c = tkc;
        start = 1'b1;
        cyc = 0; ndone = 0; lat = -1; seen = 1'b0; ax = '0; ay = '0;
        while (!seen && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) start = 1'b0;
            if (poke && cyc == 2) begin
                start = 1'b1;
                a = ~ta; b = ~tb; c = ~tc;
                coef_a = FP_ZERO;
            end
            if (poke && cyc == 3) start = 1'b0;
            if (mul_req && mul_ack) begin xq.push_back(mul_x); kq.push_back(mul_k); end
            if (add_req && add_ack) begin ax = add_x; ay = add_y; end
            if (done) begin ndone++; lat = cyc; seen = 1'b1; end
        end
        check({tag, "_timeout"}, 32'(seen), 32'd1);
        check({tag, "_latency"}, lat, 3 * (dm + 1) + (da + 1) + 2);
        check({tag, "_sig"}, 32'(sig), 32'(fadd(pa, pb) == pc));
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_busy_in_done"}, 32'(busy), 32'd1);
        check({tag, "_add_x"}, ax, pa);
        check({tag, "_add_y"}, ay, pb);
        check({tag, "_mul_count"}, xq.size(), 3);
        if (xq.size() == 3) begin
            check({tag, "_mul_x_seq"}, {xq[0], xq[1], xq[2]}, {ta, tb, tc});
            check({tag, "_mul_k_a"}, kq[0], tka);
            check({tag, "_mul_k_b"}, kq[1], tkb);
            check({tag, "_mul_k_c"}, kq[2], tkc);
        end
        if (poke) start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) ndone++;
        end
        check({tag, "_done_count"}, ndone, 1);
        check({tag, "_busy_after"}, 32'(busy), 32'd0);
        check({tag, "_sig_held"}, 32'(sig), 32'(fadd(pa, pb) == pc));
    endtask

    localparam logic [31:0] FP_NEG_ONE = 32'hBF80_0000;
    logic [31:0] coef_set [7] = '{FP_ONE, FP_NEG_ONE, 32'h4000_0000, 32'h3F00_0000,
                                  32'h4040_0000, FP_ZERO, 32'h8000_0000};

    initial begin
        int cyc, ndone;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_mul_req", 32'(mul_req), 32'd0);
        check("reset_add_req", 32'(add_req), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_sig", 32'(sig), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        check("reset_prod", add_x | add_y, FP_ZERO);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("t1_pyth", 5'd3, 5'd4, 5'd5, FP_ONE, FP_ONE, FP_ONE, 1, 1, 1'b0);
        check("t1_sig_true", 32'(sig), 32'd1);
        check("t1_add_x_lit", add_x, 32'h4110_0000);
        check("t1_add_y_lit", add_y, 32'h4180_0000);
        run_op("t1_min_lat", 5'd3, 5'd4, 5'd5, FP_ONE, FP_ONE, FP_ONE, 0, 0, 1'b0);
        run_op("t2_ne", 5'd3, 5'd4, 5'd6, FP_ONE, FP_ONE, FP_ONE, 3, 3, 1'b0);
        check("t2_sig_false", 32'(sig), 32'd0);
        run_op("t3_pos_zero", 5'd0, 5'd0, 5'd0, FP_NEG_ONE, FP_ONE, FP_ONE, 2, 1, 1'b0);
        check("t3_sig_true", 32'(sig), 32'd1);
        run_op("t3_neg_zero", 5'd0, 5'd0, 5'd0, FP_NEG_ONE, FP_ONE, FP_NEG_ONE, 1, 2, 1'b0);
        check("t3_sig_false", 32'(sig), 32'd0);
        run_op("t4_ignore", 5'd5, 5'd12, 5'd13, FP_ONE, FP_ONE, FP_ONE, 1, 0, 1'b1);
        check("t4_sig_true", 32'(sig), 32'd1);

        // Reset while the add is outstanding.
        mul_dly = 1; add_dly = 6;
        a = 5'd6; b = 5'd8; c = 5'd10;
        coef_a = FP_ONE; coef_b = FP_ONE; coef_c = FP_ONE;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!add_req && cyc < 100) begin @(negedge clk); cyc++; end
        check("t5_reached_add", 32'(add_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_busy_drop", 32'(busy), 32'd0);
        check("t5_add_req_drop", 32'(add_req), 32'd0);
        check("t5_done_low", 32'(done), 32'd0);
        ndone = 0;
        repeat (2) begin @(negedge clk); if (done) ndone++; end
        rst_n = 1'b1;
        repeat (10) begin @(negedge clk); if (done) ndone++; end
        check("t5_no_done", ndone, 0);
        run_op("t5_after", 5'd6, 5'd8, 5'd10, FP_ONE, FP_ONE, FP_ONE, 0, 2, 1'b0);

        for (int i = 0; i < 8; i++) begin
            run_op($sformatf("rnd%0d", i),
                   5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                   coef_set[$urandom_range(0, 6)], coef_set[$urandom_range(0, 6)],
                   coef_set[$urandom_range(0, 6)],
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end

`ifdef FP_SEQ_WDOG_EN
        mul_never = 1'b1;
        a = 5'd1; b = 5'd1; c = 5'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (mul_req && cyc < 100) begin cyc++; @(negedge clk); end
        check("t6_req_cycles", cyc, 16);
        check("t6_done", 32'(done), 32'd1);
        check("t6_err", 32'(err), 32'd1);
        check("t6_sig", 32'(sig), 32'd0);
        @(negedge clk);
        check("t6_idle", 32'(busy), 32'd0);
        mul_never = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
